// File: rtl/float_pkg.sv
// Shared constants and types for the binary32 multiplier exception stage.
package float_pkg;

    localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
    localparam int          FP_BIAS    = 127;
    localparam int          FP_EXP_MAX = 255;

    localparam int FLG_INVALID   = 2;
    localparam int FLG_OVERFLOW  = 1;
    localparam int FLG_UNDERFLOW = 0;

    typedef enum logic [1:0] {
        FC_ZERO,
        FC_NORMAL,
        FC_INF,
        FC_NAN
    } fp_class_e;

endpackage

// File: rtl/float_classify.sv
// Classifies a binary32 value; denormals are treated as zero.
module float_classify
    import float_pkg::*;
(
    input  logic [31:0] value,
    output fp_class_e   cls
);

    logic [7:0]  exp_field;
    logic [22:0] man_field;
    logic        unused_sign;

    assign exp_field   = value[30:23];
    assign man_field   = value[22:0];
    assign unused_sign = value[31];

    always_comb begin
        cls = FC_NORMAL;
        if (exp_field == 8'hFF) begin
            cls = (man_field != 23'd0) ? FC_NAN : FC_INF;
        end else if (exp_field == 8'h00) begin
            cls = FC_ZERO;
        end
    end

endmodule

// File: rtl/float_mult_exception_stage.sv
// Two-stage exception/range fix-up behind the combinational float multiplier,
// with valid/ready handshake and sticky exception flags.
module float_mult_exception_stage
    import float_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [31:0] raw_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_flags,
    output logic [2:0]  sticky_flags,
    input  logic        flags_clear
);

    localparam logic signed [9:0] EXP_LIMIT = 10'(FP_EXP_MAX);
    localparam logic signed [9:0] EXP_BIAS  = 10'(FP_BIAS);

    logic        s1_valid;
    logic [31:0] s1_a;
    logic [31:0] s1_b;
    logic [31:0] s1_raw;
    logic        s2_valid;
    logic [31:0] s2_data;
    logic [2:0]  s2_flags;
    logic [2:0]  sticky;
    logic        adv;

    fp_class_e   cls_a;
    fp_class_e   cls_b;
    logic        sign;
    logic        any_nan;
    logic        any_inf;
    logic        any_zero;
    logic signed [9:0] exp_sum;
    logic signed [9:0] exp_full;
    logic [7:0]  inc;
    logic [31:0] next_data;
    logic [2:0]  next_flags;
    logic        unused_raw_sign;

    float_classify u_classify_a (.value(s1_a), .cls(cls_a));
    float_classify u_classify_b (.value(s1_b), .cls(cls_b));

    assign adv          = !s2_valid || out_ready;
    assign in_ready     = rst_n && (!s1_valid || adv);
    assign out_valid    = s2_valid;
    assign out_data     = s2_data;
    assign out_flags    = s2_flags;
    assign sticky_flags = sticky;

    assign sign            = s1_a[31] ^ s1_b[31];
    assign any_nan         = (cls_a == FC_NAN) || (cls_b == FC_NAN);
    assign any_inf         = (cls_a == FC_INF) || (cls_b == FC_INF);
    assign any_zero        = (cls_a == FC_ZERO) || (cls_b == FC_ZERO);
    assign unused_raw_sign = s1_raw[31];

    // The multiplier only reports the low 8 exponent bits; recover the carry
    // from normalisation (0..2) by comparing against the unbiased sum.
    assign exp_sum  = $signed({2'b00, s1_a[30:23]}) + $signed({2'b00, s1_b[30:23]}) - EXP_BIAS;
    assign inc      = s1_raw[30:23] - exp_sum[7:0];
    assign exp_full = exp_sum + $signed({2'b00, inc});

    always_comb begin
        next_data  = {sign, s1_raw[30:0]};
        next_flags = 3'b000;
        if (any_nan || (any_inf && any_zero)) begin
            next_data                = FP_QNAN;
            next_flags[FLG_INVALID]  = 1'b1;
        end else if (any_inf) begin
            next_data = {sign, 8'hFF, 23'd0};
        end else if (any_zero) begin
            next_data = {sign, 31'd0};
        end else if (exp_full >= EXP_LIMIT) begin
            next_data                = {sign, 8'hFF, 23'd0};
            next_flags[FLG_OVERFLOW] = 1'b1;
        end else if (exp_full <= 10'sd0) begin
            next_data                 = {sign, 31'd0};
            next_flags[FLG_UNDERFLOW] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_raw   <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_flags <= '0;
            sticky   <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_a   <= op_a;
                    s1_b   <= op_b;
                    s1_raw <= raw_result;
                end
            end
            if (adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data  <= next_data;
                    s2_flags <= next_flags;
                end
            end
            // A clear coinciding with a handshake keeps only the new flags.
            if (s2_valid && out_ready) begin
                sticky <= flags_clear ? s2_flags : (sticky | s2_flags);
            end else if (flags_clear) begin
                sticky <= '0;
            end
        end
    end

endmodule
